// File: rtl/arb_rsp_router.sv
// arb_rsp_router: sits behind the round-robin arbiter tree. Forwards the
// winning request straight to a shared in-order unit, remembers the
// requester index in an ID FIFO, and steers each unit response back to the
// requester that issued it.
//
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync clear of tracking state)
//   req_valid_i / req_ready_o / req_data_i / req_idx_i : from the arbiter
//   unit_valid_o / unit_ready_i / unit_data_o          : request to unit
//   unit_rsp_valid_i / unit_rsp_ready_o / unit_rsp_data_i : unit response
//   rsp_valid_o / rsp_ready_i / rsp_data_o             : per-requester response
//   outstanding_o, busy_o, err_o                       : status
module arb_rsp_router #(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned RspWidth  = 32,
    parameter int unsigned Depth     = 4,
    parameter int unsigned IdxWidth  = $clog2(NumIn),
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic [IdxWidth-1:0]  req_idx_i,
    output logic                 unit_valid_o,
    input  logic                 unit_ready_i,
    output logic [DataWidth-1:0] unit_data_o,
    input  logic                 unit_rsp_valid_i,
    output logic                 unit_rsp_ready_o,
    input  logic [RspWidth-1:0]  unit_rsp_data_i,
    output logic [NumIn-1:0]     rsp_valid_o,
    input  logic [NumIn-1:0]     rsp_ready_i,
    output logic [RspWidth-1:0]  rsp_data_o,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [IdxWidth-1:0] id_mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] cnt;
    logic                err_q;

    logic                full;
    logic                empty;
    logic                open;
    logic                push;
    logic                pop;
    logic [IdxWidth-1:0] head;

    // Pointer advance with wrap; Depth need not be a power of two.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full  = (cnt == CntWidth'(Depth));
    assign empty = (cnt == '0);
    // Reset and flush both close the handshakes for the current cycle.
    assign open  = ~rst_i & ~flush_i;
    assign head  = id_mem[rd_ptr];

    // Request path: no payload storage; full blocks even with a same-cycle pop
    // so the request side never depends combinationally on the response side.
    assign unit_valid_o = req_valid_i & ~full & open;
    assign req_ready_o  = unit_ready_i & ~full & open;
    assign unit_data_o  = req_data_i;
    assign push         = req_valid_i & req_ready_o;

    // Response path: steer to the requester at the FIFO head.
    always_comb begin
        rsp_valid_o = '0;
        if (unit_rsp_valid_i & ~empty & open) begin
            rsp_valid_o[head] = 1'b1;
        end
    end

    assign unit_rsp_ready_o = rsp_ready_i[head] & ~empty & open;
    assign rsp_data_o       = unit_rsp_data_i;
    assign pop              = unit_rsp_valid_i & unit_rsp_ready_o;

    // ID storage; contents are don't-care until the matching push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= req_idx_i;
        end
    end

    // Pointers, occupancy and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                cnt <= cnt + CntWidth'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CntWidth'(1);
            end
            // A response with nothing outstanding has no owner.
            if (unit_rsp_valid_i && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign outstanding_o = cnt;
    assign busy_o        = (cnt != '0);
    assign err_o         = err_q;

endmodule

// File: tb/tb_arb_rsp_router.sv
module tb_arb_rsp_router;

    localparam int unsigned NumIn = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned RW    = 32;
    localparam int unsigned Depth = 4;
    localparam int unsigned IW    = 2;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_data;
    logic [IW-1:0] req_idx;
    logic          unit_valid;
    logic          unit_ready;
    logic [DW-1:0] unit_data;
    logic          unit_rsp_valid;
    logic          unit_rsp_ready;
    logic [RW-1:0] unit_rsp_data;
    logic [NumIn-1:0] rsp_valid;
    logic [NumIn-1:0] rsp_ready;
    logic [RW-1:0] rsp_data;
    logic [CW-1:0] outstanding;
    logic          busy;
    logic          err;

    int vectors   = 0;
    int miscompares = 0;

    // Reference model: queue of requester indices in acceptance order.
    int q[$];
    bit m_err;

    arb_rsp_router #(
        .NumIn(NumIn), .DataWidth(DW), .RspWidth(RW), .Depth(Depth)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_data_i(req_data), .req_idx_i(req_idx),
        .unit_valid_o(unit_valid), .unit_ready_i(unit_ready), .unit_data_o(unit_data),
        .unit_rsp_valid_i(unit_rsp_valid), .unit_rsp_ready_o(unit_rsp_ready),
        .unit_rsp_data_i(unit_rsp_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .outstanding_o(outstanding), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check every output against the model at the
    // falling edge, then advance the model to the state after the next edge.
    task automatic step(input bit r, input bit f, input bit rv, input logic [DW-1:0] rd,
                        input int ri, input bit ur, input bit urv,
                        input logic [RW-1:0] urd, input logic [NumIn-1:0] rr);
        bit full, empty, e_req_ready, e_unit_valid, e_urr, push, pop;
        int head;
        logic [NumIn-1:0] e_rsp_valid;
        @(posedge clk);
        #1;
        rst = r; flush = f; req_valid = rv; req_data = rd; req_idx = IW'(ri);
        unit_ready = ur; unit_rsp_valid = urv; unit_rsp_data = urd; rsp_ready = rr;
        @(negedge clk);
        full  = (q.size() == Depth);
        empty = (q.size() == 0);
        head  = empty ? 0 : q[0];
        e_req_ready  = !r && !f && ur && !full;
        e_unit_valid = !r && !f && rv && !full;
        e_urr        = !r && !f && !empty && rr[head];
        e_rsp_valid  = (!r && !f && urv && !empty) ? NumIn'(1 << head) : '0;
        chk("req_ready", 64'(req_ready), 64'(e_req_ready));
        chk("unit_valid", 64'(unit_valid), 64'(e_unit_valid));
        chk("unit_data", 64'(unit_data), 64'(rd));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
        chk("unit_rsp_ready", 64'(unit_rsp_ready), 64'(e_urr));
        chk("rsp_data", 64'(rsp_data), 64'(urd));
        chk("outstanding", 64'(outstanding), 64'(q.size()));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("err", 64'(err), 64'(m_err));
        if (r || f) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            push = rv && e_req_ready;
            pop  = urv && e_urr;
            if (urv && empty) m_err = 1'b1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(ri);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0, 1, 0, '0, '1);
    endtask

    task automatic push_idx(input int i, input logic [DW-1:0] d);
        step(0, 0, 1, d, i, 1, 0, '0, '1);
    endtask

    task automatic pop_one(input logic [RW-1:0] d);
        step(0, 0, 0, '0, 0, 1, 1, d, '1);
    endtask

    initial begin
        rst = 1; flush = 0; req_valid = 0; req_data = '0; req_idx = '0;
        unit_ready = 0; unit_rsp_valid = 0; unit_rsp_data = '0; rsp_ready = '0;
        m_err = 0;
        repeat (2) @(posedge clk);

        // Reset: handshakes closed even with all inputs active.
        step(1, 0, 1, 32'h1, 1, 1, 1, 32'h2, '1);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        idle();
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // Single transaction from requester 2.
        push_idx(2, 32'hA5);
        chk("single_req_ready", 64'(req_ready), 64'd1);
        idle();
        chk("single_outstanding", 64'(outstanding), 64'd1);
        pop_one(32'h5A);
        chk("single_rsp_valid", 64'(rsp_valid), 64'b0100);
        chk("single_rsp_data", 64'(rsp_data), 64'h5A);
        idle();
        chk("single_done_cnt", 64'(outstanding), 64'd0);
        chk("single_done_busy", 64'(busy), 64'd0);

        // Fill to full, blocked 5th, pop+push same cycle blocked, then push.
        for (int i = 0; i < 4; i++) push_idx(i, DW'(i));
        push_idx(3, 32'h33);
        chk("full_blocked", 64'(req_ready), 64'd0);
        chk("full_cnt", 64'(outstanding), 64'd4);
        step(0, 0, 1, 32'h33, 3, 1, 1, 32'h100, '1);
        chk("full_pop_rsp", 64'(rsp_valid), 64'b0001);
        chk("full_push_blocked", 64'(req_ready), 64'd0);
        push_idx(3, 32'h33);
        chk("refill_ready", 64'(req_ready), 64'd1);
        begin
            int order[4] = '{1, 2, 3, 3};
            for (int i = 0; i < 4; i++) begin
                pop_one(RW'(i));
                chk("order", 64'(rsp_valid), 64'(1 << order[i]));
            end
        end

        // Back-pressure on requester 1.
        push_idx(1, 32'h11);
        idle();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, '0, 0, 1, 1, 32'h77, 4'b1101);
            chk("bp_hold", 64'(rsp_valid), 64'b0010);
            chk("bp_ready", 64'(unit_rsp_ready), 64'd0);
        end
        step(0, 0, 0, '0, 0, 1, 1, 32'h77, 4'b1111);
        chk("bp_release", 64'(unit_rsp_ready), 64'd1);

        // Simultaneous push and pop at occupancy 2, across pointer wrap.
        push_idx(0, 32'h0);
        push_idx(1, 32'h1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, DW'(i), (i + 2) % 4, 1, 1, RW'(i), '1);
            chk("pp_cnt", 64'(outstanding), 64'd2);
        end
        pop_one(32'h1);
        pop_one(32'h2);

        // Error flag: response while empty, sticky until flush.
        step(0, 0, 0, '0, 0, 1, 1, 32'hEE, '1);
        chk("err_urr", 64'(unit_rsp_ready), 64'd0);
        idle();
        chk("err_set", 64'(err), 64'd1);
        idle();
        idle();
        chk("err_sticky", 64'(err), 64'd1);
        step(0, 1, 0, '0, 0, 1, 0, '0, '1);
        idle();
        chk("err_cleared", 64'(err), 64'd0);

        // Flush with three outstanding.
        for (int i = 0; i < 3; i++) push_idx(i + 1, DW'(i));
        step(0, 1, 1, 32'h9, 2, 1, 1, 32'h9, '1);
        chk("flush_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("flush_req_ready", 64'(req_ready), 64'd0);
        push_idx(2, 32'h22);
        chk("flush_resume", 64'(req_ready), 64'd1);
        chk("flush_cnt", 64'(outstanding), 64'd0);
        pop_one(32'h22);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit r, f, urv;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 59) == 0);
            if (q.size() == 0) urv = ($urandom_range(0, 29) == 0);
            else               urv = ($urandom_range(0, 9) < 6);
            step(r, f, $urandom_range(0, 1) == 1, DW'($urandom), int'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 7, urv, RW'($urandom), NumIn'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
